ap_ctrl_driver: RTL

// Synthesizable initiator for the HLS block-level ap_ctrl_chain / ap_ctrl_hs handshake: drives ap_start and
// ap_continue into a kernel (e.g. gravity) and consumes ap_ready/ap_done. Issues a programmed number of

---
 rtl/ap_ctrl_driver.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ap_ctrl_driver.sv
// ---------------------------------------------------------------------------
// ap_ctrl_driver
//
// Initiator for the HLS block-level ap_ctrl_chain / ap_ctrl_hs handshake.
// It drives ap_start / ap_continue into a kernel and consumes ap_ready /
// ap_done. It issues a programmed number of transactions and lets up to
// MAX_OUT of them overlap. It measures the latency of each transaction, from
// the first cycle its ap_start is high to the cycle its done handshake
// completes.
//
// Ports
//   clock, reset       single rising-edge clock, synchronous active-high reset
//   cfg_start          1-cycle pulse that begins a run; ignored while busy
//   cfg_num_txn        transactions to issue; sampled on an accepted cfg_start
//   cfg_gap            ap_continue low time after each retire; sampled with cfg_start
//   ap_start (out)     kernel start request; held until ap_ready once raised
//   ap_ready (in)      kernel accepted the current inputs
//   ap_done  (in)      kernel finished the oldest outstanding transaction
//   ap_continue (out)  lets the kernel retire ap_done
//   busy               run in progress (RUN or DRAIN)
//   finish             level: run complete; cleared by the next accepted cfg_start
//   txn_issued         issue handshakes this run
//   txn_done           done handshakes this run
//   last_latency       latency of the most recently retired transaction
//   max_latency        largest latency seen this run
//   err_protocol       sticky protocol-violation flag
// ---------------------------------------------------------------------------
module ap_ctrl_driver #(
    parameter int CNT_W   = 16,
    parameter int LAT_W   = 32,
    parameter int MAX_OUT = 4,
    parameter int GAP_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_num_txn,
    input  logic [GAP_W-1:0] cfg_gap,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] txn_issued,
    output logic [CNT_W-1:0] txn_done,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] max_latency,
    output logic             err_protocol
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OCC_W = $clog2(MAX_OUT + 1);
    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_n;

    // run configuration captured at cfg_start
    logic [CNT_W-1:0] num;
    logic [GAP_W-1:0] gap;

    // ap_continue back-pressure counter
    logic [GAP_W-1:0] gcnt;

    // free-running timestamp and start time of the transaction now on ap_start
    logic [LAT_W-1:0] ts;
    logic [LAT_W-1:0] start_ts;

    // start-timestamp FIFO, one entry per outstanding transaction
    logic [LAT_W-1:0] fifo [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ, occ_n;

    logic             iss, dn, in_run, accept, vdone, bypass;
    logic             push, pop, err_set, ap_start_n;
    logic [CNT_W-1:0] issued_inc;
    logic [LAT_W-1:0] lat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // handshake decode
    // -----------------------------------------------------------------------
    assign ap_continue = (gcnt == '0);
    assign busy        = (state == S_RUN) || (state == S_DRAIN);

    assign iss    = ap_start && ap_ready;
    assign dn     = ap_done && ap_continue;
    assign in_run = busy;
    assign accept = cfg_start && ((state == S_IDLE) || (state == S_DONE));

    // A done is legitimate only while a run is active and something is in
    // flight, counting a transaction issued in this very cycle.
    assign vdone  = dn && in_run && ((occ != '0) || iss);

    // Same-cycle issue and done with an empty FIFO: the entry being pushed is
    // the one being popped, so take the start time straight from start_ts.
    assign bypass = (occ == '0) && iss;
    assign push   = iss && !(vdone && (occ == '0));
    assign pop    = vdone && (occ != '0);

    assign lat        = ts - (bypass ? start_ts : fifo[rd_ptr]);
    assign issued_inc = txn_issued + CNT_W'(iss);
    assign occ_n      = occ + OCC_W'(iss) - OCC_W'(vdone);

    // Spurious dones (nothing outstanding, or no run active) and ap_ready
    // without a pending start are both flagged.
    assign err_set = (dn && !vdone) || (ap_ready && !ap_start);

    // -----------------------------------------------------------------------
    // next-state and next ap_start
    // -----------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        ap_start_n = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (cfg_start)
                    state_n = (cfg_num_txn == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (iss && (issued_inc == num))
                    state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (txn_done == num)
                    state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase

        // Once raised, ap_start is never withdrawn before ap_ready. A fresh
        // request is only made while budget and FIFO room remain after this
        // cycle's handshakes.
        if (ap_start && !ap_ready)
            ap_start_n = 1'b1;
        else if ((state == S_RUN) && (issued_inc < num) && (occ_n < OCC_MAX))
            ap_start_n = 1'b1;
    end

    // -----------------------------------------------------------------------
    // state, counters, latency tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            ts           <= '0;
            start_ts     <= '0;
            ap_start     <= 1'b0;
            gcnt         <= '0;
            num          <= '0;
            gap          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            txn_issued   <= '0;
            txn_done     <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            err_protocol <= 1'b0;
            finish       <= 1'b0;
        end else begin
            state    <= state_n;
            ts       <= ts + 1'b1;
            ap_start <= ap_start_n;

            // ap_start is registered, so the first high cycle of the next
            // transaction carries timestamp ts+1.
            if (ap_start_n && (!ap_start || iss))
                start_ts <= ts + 1'b1;

            if (vdone)
                gcnt <= gap;
            else if (gcnt != '0)
                gcnt <= gcnt - 1'b1;

            if (accept) begin
                num          <= cfg_num_txn;
                gap          <= cfg_gap;
                txn_issued   <= '0;
                txn_done     <= '0;
                last_latency <= '0;
                max_latency  <= '0;
                err_protocol <= err_set;
                finish       <= (cfg_num_txn == '0);
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                occ          <= '0;
            end else begin
                if (iss)
                    txn_issued <= issued_inc;
                if (vdone) begin
                    txn_done     <= txn_done + 1'b1;
                    last_latency <= lat;
                    if (lat > max_latency)
                        max_latency <= lat;
                end
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                occ <= occ_n;
                if (err_set)
                    err_protocol <= 1'b1;
                if ((state == S_DRAIN) && (state_n == S_DONE))
                    finish <= 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push)
            fifo[wr_ptr] <= start_ts;
    end

endmodule
